// File: rtl/dm_sysbus_access.sv
// System Bus Access engine for the RISC-V Debug Module: decodes SBCS/SBADDRESS0/SBDATA0
// and runs single-beat req/gnt/rvalid bus transactions with error and timeout reporting.
module dm_sysbus_access #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmi_valid,
  input  logic              dmi_write,
  input  logic [6:0]        dmi_addr,
  input  logic [31:0]       dmi_wdata,
  output logic [31:0]       dmi_rdata,
  output logic              dmi_rvalid,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err
);

  localparam logic [6:0] A_SBCS   = 7'h38;
  localparam logic [6:0] A_SBADDR = 7'h39;
  localparam logic [6:0] A_SBDATA = 7'h3C;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  state_t state_q, state_d;

  logic              busyerr_q, roa_q, autoinc_q, rod_q;
  logic [2:0]        access_q, sberr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        size_q;

  logic              busy, hit_cs, hit_ad, hit_dt, trig, go_ok, bad_size, misaligned;
  logic              launch, done, tmo, start_we;
  logic [ADDR_W-1:0] start_addr;
  logic [31:0]       start_data, wdata_d, rd_shift, rd_ext, sbcs;
  logic [3:0]        be_d;

  assign busy    = (state_q != S_IDLE);
  assign bus_req = (state_q == S_REQ);
  assign hit_cs  = dmi_valid && (dmi_addr == A_SBCS);
  assign hit_ad  = dmi_valid && (dmi_addr == A_SBADDR);
  assign hit_dt  = dmi_valid && (dmi_addr == A_SBDATA);

  assign sbcs = {3'd1, 6'd0, busyerr_q, busy, roa_q, access_q, autoinc_q, rod_q,
                 sberr_q, 7'(ADDR_W), 5'b00111};

  // A transfer is judged against the address/data that the same access loads.
  assign start_we   = hit_dt && dmi_write;
  assign start_addr = (hit_ad && dmi_write) ? dmi_wdata[ADDR_W-1:0] : addr_q;
  assign start_data = start_we ? dmi_wdata : data_q;
  assign trig       = !busy && ((hit_ad && dmi_write && roa_q) || start_we ||
                                (hit_dt && !dmi_write && rod_q));
  assign go_ok      = trig && !busyerr_q && (sberr_q == 3'd0);
  assign bad_size   = (access_q > 3'd2);
  assign misaligned = ((access_q == 3'd1) && start_addr[0]) ||
                      ((access_q == 3'd2) && (start_addr[1:0] != 2'b00));
  assign launch     = go_ok && !bad_size && !misaligned;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = start_data;
    case (access_q[1:0])
      2'd0: begin be_d = 4'b0001 << start_addr[1:0]; wdata_d = {4{start_data[7:0]}}; end
      2'd1: begin be_d = 4'b0011 << start_addr[1:0]; wdata_d = {2{start_data[15:0]}}; end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift = bus_rdata >> {bus_addr[1:0], 3'b000};
    rd_ext   = bus_rdata;
    case (size_q)
      2'd0:    rd_ext = {24'd0, rd_shift[7:0]};
      2'd1:    rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = bus_rdata;
    endcase
  end

  // Completion wins over timeout in the last allowed cycle.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE: if (launch) state_d = S_REQ;
      S_REQ: begin
        if (bus_gnt && bus_rvalid) begin done = 1'b1; state_d = S_IDLE; end
        else if (cnt_q == CNT_LAST) begin tmo = 1'b1; state_d = S_IDLE; end
        else if (bus_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus_rvalid) begin done = 1'b1; state_d = S_IDLE; end
        else if (cnt_q == CNT_LAST) begin tmo = 1'b1; state_d = S_IDLE; end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_IDLE || state_d == S_IDLE) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyerr_q <= 1'b0;
      roa_q     <= 1'b0;
      access_q  <= 3'd2;
      autoinc_q <= 1'b0;
      rod_q     <= 1'b0;
      sberr_q   <= 3'd0;
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= 2'd2;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      if (hit_cs && dmi_write) begin
        roa_q     <= dmi_wdata[20];
        access_q  <= dmi_wdata[19:17];
        autoinc_q <= dmi_wdata[16];
        rod_q     <= dmi_wdata[15];
        if (dmi_wdata[22]) busyerr_q <= 1'b0;
        sberr_q   <= sberr_q & ~dmi_wdata[14:12];
      end
      if (busy && (hit_ad || hit_dt)) busyerr_q <= 1'b1;
      if (!busy && hit_ad && dmi_write) addr_q <= dmi_wdata[ADDR_W-1:0];
      if (start_we && !busy) data_q <= dmi_wdata;
      if (go_ok && bad_size)        sberr_q <= 3'd4;
      else if (go_ok && misaligned) sberr_q <= 3'd3;
      if (launch) begin
        bus_we    <= start_we;
        bus_addr  <= start_addr;
        bus_wdata <= wdata_d;
        bus_be    <= be_d;
        size_q    <= access_q[1:0];
      end
      // Later assignments win, so a fresh error overrides a same-cycle W1C.
      if (done) begin
        if (bus_err) sberr_q <= 3'd2;
        else begin
          if (!bus_we) data_q <= rd_ext;
          if (autoinc_q) addr_q <= addr_q + (ADDR_W'(1) << size_q);
        end
      end
      if (tmo) sberr_q <= 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmi_rvalid <= 1'b0;
      dmi_rdata  <= '0;
    end else begin
      dmi_rvalid <= !dmi_write && (hit_cs || hit_ad || hit_dt);
      if (!dmi_write && (hit_cs || hit_ad || hit_dt)) begin
        if (hit_cs)      dmi_rdata <= sbcs;
        else if (hit_ad) dmi_rdata <= 32'(addr_q);
        else             dmi_rdata <= data_q;
      end
    end
  end

endmodule

// File: doc/dm_sysbus_access.md
# dm_sysbus_access

System Bus Access engine for the RISC-V Debug Module. It decodes the SBCS (0x38), SBADDRESS0 (0x39) and SBDATA0 (0x3C) DMI registers and turns them into real single-beat bus transactions with a req/gnt/rvalid handshake. It supports parametrised address width, 8/16/32-bit accesses, auto-increment, read-on-addr, read-on-data, a bus timeout and full error reporting. It sits beside the DMI register decoder, which forwards only these three addresses to it.

## Interface
Parameters:
- ADDR_W, 32: bus address width, 12..32; reported in sbasize.
- TIMEOUT, 255: cycles allowed from bus_req to bus_rvalid before sberror=1; must be ≥1.

Ports:
- clk  in  1  clock; all logic is posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- dmi_valid  in  1  one-cycle DMI access strobe.
- dmi_write  in  1  1=DMI write, 0=DMI read.
- dmi_addr  in  7  register address; only 0x38/0x39/0x3C are decoded, all others are ignored.
- dmi_wdata  in  32  DMI write data.
- dmi_rdata  out  32  read data; valid when dmi_rvalid is high.
- dmi_rvalid  out  1  one-cycle pulse, one cycle after a DMI read of a decoded address.
- bus_req  out  1  transaction request; held until bus_gnt.
- bus_we  out  1  1=write.
- bus_addr  out  ADDR_W  byte address, stable while bus_req is high.
- bus_wdata  out  32  write data, replicated across lanes.
- bus_be  out  4  byte enables.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  completion, for reads and writes alike.
- bus_rdata  in  32  read data, qualified by bus_rvalid.
- bus_err  in  1  error completion, qualified by bus_rvalid.

## Operation
- **SBCS read view:**
  - [31:29] sbversion = 1
  - [22] sbbusyerror
  - [21] sbbusy
  - [20] sbreadonaddr
  - [19:17] sbaccess
  - [16] sbautoincrement
  - [15] sbreadondata
  - [14:12] sberror
  - [11:5] sbasize = ADDR_W
  - [4:0] = 5'b00111 (access8/16/32 supported)
  - All other bits read 0.
- **SBCS write:**
  - Bits 20, 19:17, 16 and 15 are written unconditionally, even while busy.
  - Bit 22 is write-1-to-clear.
  - Bits 14:12 are write-1-to-clear per bit.
- **SBADDRESS0:** holds ADDR_W bits; upper bits read 0 and are ignored on write.
  - A write loads the address.
  - If sbreadonaddr=1, the write then starts a read.
- **SBDATA0 write:** loads the data and starts a write.
- **SBDATA0 read:** returns the current data.
  - If sbreadondata=1, it then starts a read at the current address.
- **Gating rules:**
  - A transfer starts only if sbbusyerror=0 and sberror=0. Otherwise the register update still happens and no transfer is issued.
  - Any SBADDRESS0/SBDATA0 access while sbbusy=1 sets sbbusyerror. The access is then ignored: no register update, no new transfer. Reads return the stale value.
- **Pre-checks at start** (no bus activity; sberror set):
  - sbaccess > 2 → sberror=4.
  - Address misaligned for the size (size 1: addr[0]≠0; size 2: addr[1:0]≠0) → sberror=3.
- **Lanes:**
  - size 0: bus_be = 1<<addr[1:0].
  - size 1: bus_be = 4'b0011<<addr[1:0].
  - size 2: bus_be = 4'b1111.
  - Write data: the low byte or halfword is replicated across all lanes.
  - Read data: the addressed lane is extracted and zero-extended into SBDATA0.
- **FSM:**
  - IDLE → REQ on a valid start.
  - REQ: bus_req=1 → RESP on bus_gnt.
  - RESP → IDLE on bus_rvalid.
  - The timeout counter runs in REQ and RESP; on reaching TIMEOUT → IDLE with sberror=1. A late bus_rvalid after a timeout is ignored.
- **Completion:**
  - bus_err=1 → sberror=2; SBDATA0 and the address are unchanged.
  - Otherwise a read loads SBDATA0.
  - If sbautoincrement=1, the address increments by 1<<sbaccess, wrapping modulo 2^ADDR_W.
  - No increment on any error.

## Timing
- **Reset values:**
  - Outputs: dmi_rdata=0, dmi_rvalid=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0.
  - Internal: sbaccess=2, all other SBCS fields 0, SBADDRESS0=0, SBDATA0=0, FSM in IDLE, counter 0.
- **sbbusy:**
  - Rises the cycle after the triggering DMI access. In that same cycle, bus_req and the address/data/be are driven.
  - Falls the cycle after bus_rvalid or timeout. SBDATA0, the address and sberror update on that same edge.
- **Minimum latency:** trigger → bus_req 1 cycle; gnt and rvalid in consecutive cycles → sbbusy low 3 cycles after the trigger.
- **Simultaneous bus_gnt and bus_rvalid in REQ:** treated as complete; go directly to IDLE.
- **Read-on-data:** dmi_rdata captures the pre-read value. The new read begins on the same edge dmi_rvalid rises.
- **SBCS W1C vs. new error:** a W1C in the same cycle as a new error sets the error (new error wins).
- **Mid-transfer reset:** rst_n low mid-transfer drops bus_req immediately (asynchronously) and abandons the transfer.

## Test plan
- SBCS read after reset → dmi_rdata=0x2004_0407 (ADDR_W=32); dmi_rvalid pulses exactly once.
- sbaccess=2, addr 0x1000, write SBDATA0=0xDEADBEEF, gnt after 2 cycles, rvalid 1 cycle later → bus_we=1, bus_be=F, bus_wdata=0xDEADBEEF; sbbusy returns 0, sberror=0.
- sbaccess=0, autoinc=1, readonaddr=1, write addr 0x2003, bus_rdata=0xAABBCCDD → SBDATA0=0x000000AA, bus_be=4'b1000, address becomes 0x2004.
- sbaccess=1, addr 0x3001, write SBDATA0 → no bus_req, sberror=3; a further SBDATA0 write issues nothing until SBCS is written with 0x7000.
- Hold bus_gnt low for TIMEOUT cycles → sberror=1 and sbbusy low. Separately, a SBDATA0 write while busy → sbbusyerror=1 and the held data is unchanged.
- readondata=1, autoinc=1, sbaccess=2: three SBDATA0 reads against memory 0x11/0x22/0x33 at 0x0/0x4/0x8 → the 2nd and 3rd reads return 0x11 then 0x22; the final address is 0xC.
